// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM authentication front-end.
// Optional inactivity abort is enabled by defining ATM_TIMEOUT_EN.
package atm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_GRANTED
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam int         CARD_W    = 8;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/atm_pin_shift_reg.sv
// BCD PIN digit shifter with saturating digit count and reference compare.
// Part of atm_auth_unit (optional ATM_TIMEOUT_EN lives in the top).
module atm_pin_shift_reg
  import atm_pkg::*;
#(
  parameter  int PIN_DIGITS = 4,
  localparam int CW = cnt_w(PIN_DIGITS),
  localparam int BW = 4 * PIN_DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [3:0]    digit,
  input  logic [BW-1:0] ref_pin,
  output logic [CW-1:0] cnt,
  output logic          match
);

  logic [BW-1:0] pin_q;
  logic          full;

  assign full  = (cnt == CW'(PIN_DIGITS));
  assign match = (pin_q == ref_pin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_q <= '0;
      cnt   <= '0;
    end else begin
      unique case (1'b1)
        clr: begin
          pin_q <= '0;
          cnt   <= '0;
        end
        push && !full: begin
          pin_q <= {pin_q[BW-5:0], digit};
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/atm_auth_unit.sv
// Card/PIN authentication stage ahead of the ATM session FSM.
// Define ATM_TIMEOUT_EN to abort a session idle in COLLECT.
module atm_auth_unit
  import atm_pkg::*;
#(
  parameter  int PIN_DIGITS  = 4,
  parameter  int MAX_TRIES   = 3,
  parameter  int TIMEOUT_CYC = 20,
  localparam int CW = cnt_w(PIN_DIGITS),
  localparam int TW = cnt_w(MAX_TRIES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    card_in,
  input  logic [CARD_W-1:0]       card_no,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic [4*PIN_DIGITS-1:0] ref_pin,
  input  logic                    session_end,
  output logic                    auth_ok,
  output logic [CARD_W-1:0]       card_id,
  output logic [CW-1:0]           digit_cnt,
  output logic [TW-1:0]           tries_left,
  output logic                    bad_pin,
  output logic                    card_retain,
  output logic                    timeout
);

  state_t state;
  logic   match;
  logic   to_fire;
  logic   is_digit;
  logic   card_ok;
  logic   buf_clr;
  logic   buf_push;

  assign is_digit = (key_code <= 4'd9);
  assign card_ok  = card_in && (card_no != '0);

  assign buf_push = (state == S_COLLECT) && key_valid && is_digit;
  assign buf_clr  = ((state == S_IDLE) && card_ok)
                 || ((state == S_COLLECT) && key_valid
                     && (key_code == KEY_CLEAR))
                 || ((state == S_CHECK) && !match)
                 || ((state == S_GRANTED) && session_end)
                 || to_fire;

  atm_pin_shift_reg #(
    .PIN_DIGITS(PIN_DIGITS)
  ) u_pin (
    .clk    (clk),
    .rst    (rst),
    .clr    (buf_clr),
    .push   (buf_push),
    .digit  (key_code),
    .ref_pin(ref_pin),
    .cnt    (digit_cnt),
    .match  (match)
  );

`ifdef ATM_TIMEOUT_EN
  localparam int IW = cnt_w(TIMEOUT_CYC);
  logic [IW-1:0] idle_cnt;

  // A key in the expiry cycle wins over the abort.
  assign to_fire = (state == S_COLLECT) && !key_valid
                && (idle_cnt == IW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= to_fire;
      if (state != S_COLLECT || key_valid || to_fire)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      auth_ok     <= 1'b0;
      card_id     <= '0;
      tries_left  <= TW'(MAX_TRIES);
      bad_pin     <= 1'b0;
      card_retain <= 1'b0;
    end else begin
      bad_pin     <= 1'b0;
      card_retain <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (card_ok) begin
            card_id    <= card_no;
            tries_left <= TW'(MAX_TRIES);
            state      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (to_fire) begin
            card_id <= '0;
            state   <= S_IDLE;
          end else if (key_valid && key_code == KEY_ENTER
                       && digit_cnt == CW'(PIN_DIGITS)) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (match) begin
            state <= S_GRANTED;
          end else if (tries_left > TW'(1)) begin
            tries_left <= tries_left - TW'(1);
            bad_pin    <= 1'b1;
            state      <= S_COLLECT;
          end else begin
            tries_left  <= '0;
            card_retain <= 1'b1;
            card_id     <= '0;
            state       <= S_IDLE;
          end
        end
        S_GRANTED: begin
          if (session_end) begin
            auth_ok <= 1'b0;
            card_id <= '0;
            state   <= S_IDLE;
          end else begin
            auth_ok <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_auth_unit.sv
// Directed self-checking bench for atm_auth_unit.
// Timeout cases run only when ATM_TIMEOUT_EN is defined.
module tb_atm_auth_unit;
  import atm_pkg::*;

  logic        clk;
  logic        rst;
  logic        card_in;
  logic [7:0]  card_no;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] ref_pin;
  logic        session_end;
  logic        auth_ok;
  logic [7:0]  card_id;
  logic [2:0]  digit_cnt;
  logic [1:0]  tries_left;
  logic        bad_pin;
  logic        card_retain;
  logic        timeout;

  int checks;
  int failures;

  atm_auth_unit dut (
    .clk        (clk),
    .rst        (rst),
    .card_in    (card_in),
    .card_no    (card_no),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .ref_pin    (ref_pin),
    .session_end(session_end),
    .auth_ok    (auth_ok),
    .card_id    (card_id),
    .digit_cnt  (digit_cnt),
    .tries_left (tries_left),
    .bad_pin    (bad_pin),
    .card_retain(card_retain),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic card(input logic [7:0] no);
    card_in = 1'b1;
    card_no = no;
    tick();
    card_in = 1'b0;
    card_no = 8'h00;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic keys4(input logic [15:0] p);
    logic [15:0] v;
    v = p;
    for (int i = 3; i >= 0; i--) key(v[4*i +: 4]);
  endtask

  task automatic end_session();
    session_end = 1'b1;
    tick();
    session_end = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    card_in     = 1'b0;
    card_no     = 8'h00;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    ref_pin     = 16'h1234;
    session_end = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_auth",  auth_ok, 0);
    check("rst_card",  card_id, 0);
    check("rst_cnt",   digit_cnt, 0);
    check("rst_tries", tries_left, 3);
    check("rst_bad",   bad_pin, 0);
    check("rst_ret",   card_retain, 0);
    check("rst_to",    timeout, 0);
    tick();
    #3 rst = 1'b0;
    tick();

    // good PIN, auth latency, session end
    card(8'h5A);
    check("t1_card",  card_id, 8'h5A);
    check("t1_tries", tries_left, 3);
    keys4(16'h1234);
    check("t1_cnt4", digit_cnt, 4);
    key(KEY_ENTER);
    check("t1_auth_n", auth_ok, 0);
    tick();
    check("t1_auth_n1", auth_ok, 0);
    tick();
    check("t1_auth_n2", auth_ok, 1);
    check("t1_card_g",  card_id, 8'h5A);
    check("t1_tries_g", tries_left, 3);
    end_session();
    check("t1_end_auth", auth_ok, 0);
    check("t1_end_card", card_id, 0);
    check("t1_end_cnt",  digit_cnt, 0);

    // one wrong PIN, then good; card_in ignored mid-session
    card(8'h33);
    card(8'h44);
    check("t2_card_keep", card_id, 8'h33);
    keys4(16'h9999);
    key(KEY_ENTER);
    tick();
    check("t2_bad",   bad_pin, 1);
    check("t2_tries", tries_left, 2);
    check("t2_cnt0",  digit_cnt, 0);
    tick();
    check("t2_bad_clr", bad_pin, 0);
    keys4(16'h1234);
    key(KEY_ENTER);
    tick();
    tick();
    check("t2_auth", auth_ok, 1);
    end_session();

    // three wrong PINs -> retain
    card(8'h77);
    for (int t = 0; t < 3; t++) begin
      keys4(16'h9999);
      key(KEY_ENTER);
      tick();
      check($sformatf("t3_bad%0d", t), bad_pin, (t < 2) ? 1 : 0);
      check($sformatf("t3_ret%0d", t), card_retain, (t == 2) ? 1 : 0);
      check($sformatf("t3_tries%0d", t), tries_left, 2 - t);
    end
    check("t3_card0", card_id, 0);
    tick();
    check("t3_ret_clr", card_retain, 0);
    key(4'h1);
    check("t3_idle_key", digit_cnt, 0);
    card(8'h00);
    check("t3_zero_card", card_id, 0);
    key(4'h1);
    check("t3_still_idle", digit_cnt, 0);

    // clear, short enter, saturation
    card(8'h5A);
    key(4'h1);
    key(4'h2);
    check("t4_cnt2", digit_cnt, 2);
    key(KEY_CLEAR);
    check("t4_cnt0", digit_cnt, 0);
    key(4'h1);
    key(4'h2);
    key(4'h3);
    key(KEY_ENTER);
    tick();
    tick();
    check("t4_short_auth", auth_ok, 0);
    check("t4_short_cnt",  digit_cnt, 3);
    key(4'hE);
    check("t4_ign_code", digit_cnt, 3);
    key(4'h4);
    key(4'h5);
    check("t4_sat", digit_cnt, 4);
    key(KEY_ENTER);
    tick();
    tick();
    check("t4_auth", auth_ok, 1);
    key(4'h7);
    check("t4_g_key_cnt", digit_cnt, 4);
    check("t4_g_key_auth", auth_ok, 1);
    key_valid   = 1'b1;
    key_code    = 4'h1;
    session_end = 1'b1;
    tick();
    key_valid   = 1'b0;
    session_end = 1'b0;
    check("t4_se_wins", auth_ok, 0);
    check("t4_se_card", card_id, 0);
    check("t4_se_cnt",  digit_cnt, 0);

`ifdef ATM_TIMEOUT_EN
    card(8'h66);
    for (int i = 1; i < 20; i++) tick();
    check("t5_no_to19", timeout, 0);
    tick();
    check("t5_to20",   timeout, 1);
    check("t5_card0",  card_id, 0);
    tick();
    check("t5_to_clr", timeout, 0);
    card(8'h66);
    for (int i = 1; i < 20; i++) tick();
    key(4'h1);
    check("t5_key_wins", timeout, 0);
    check("t5_key_card", card_id, 8'h66);
    for (int i = 1; i < 20; i++) tick();
    check("t5_rst19", timeout, 0);
    tick();
    check("t5_rst20", timeout, 1);
    tick();
`else
    check("t5_to_tied", timeout, 0);
`endif

    // async reset in GRANTED
    card(8'h5A);
    keys4(16'h1234);
    key(KEY_ENTER);
    tick();
    tick();
    check("t6_auth", auth_ok, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_auth", auth_ok, 0);
    check("t6_rst_card", card_id, 0);
    check("t6_rst_cnt",  digit_cnt, 0);
    #1 rst = 1'b0;
    tick();
    card(8'h21);
    check("t6_new_card",  card_id, 8'h21);
    check("t6_new_tries", tries_left, 3);
    check("t6_new_cnt",   digit_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_auth_unit.md
Name: atm_auth_unit

Overview:
- Front-end stage that sits directly upstream of the ATM session FSM.
- Latches the inserted card number, collects keypad PIN digits, compares the PIN against the reference PIN and tracks remaining tries.
- On success, grants an authenticated session to the downstream FSM; on repeated failure, retains the card; on inactivity, aborts.
- The downstream FSM consumes auth_ok/card_id and returns session_end.

Parameters:
- PIN_DIGITS, 4, number of BCD digits in a PIN.
- MAX_TRIES, 3, wrong-PIN attempts allowed before card retention.
- TIMEOUT_CYC, 20, idle cycles in COLLECT before abort (only with ATM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- card_in  in  1  one-cycle pulse: card inserted.
- card_no  in  8  card number, sampled when card_in=1.
- key_valid  in  1  one-cycle keypad strobe.
- key_code  in  4  0-9 digit, 0xA clear, 0xB enter, 0xC-0xF ignored.
- ref_pin  in  4*PIN_DIGITS  reference PIN (BCD, first-entered digit in MS nibble); stable while a card is in.
- session_end  in  1  pulse from downstream: customer finished.
- auth_ok  out  1  level: authenticated session active.
- card_id  out  8  latched card number; 0 when no card.
- digit_cnt  out  clog2(PIN_DIGITS+1)  digits currently entered (for display masking).
- tries_left  out  clog2(MAX_TRIES+1)  remaining attempts.
- bad_pin  out  1  one-cycle pulse on wrong PIN with tries remaining.
- card_retain  out  1  one-cycle pulse on final wrong PIN.
- timeout  out  1  one-cycle pulse on inactivity abort.

Behaviour:
- Reset values: state IDLE; auth_ok=0, card_id=0, digit_cnt=0, tries_left=MAX_TRIES, all pulses 0, PIN buffer 0.
- All outputs are registered.
- States: IDLE, COLLECT, CHECK, GRANTED.
- IDLE:
  - card_in=1 -> latch card_id=card_no, tries_left=MAX_TRIES, clear buffer and digit_cnt, go to COLLECT.
  - card_in with card_no==0 is ignored.
  - Keys are ignored.
- COLLECT:
  - Digit key with digit_cnt<PIN_DIGITS: shift buffer left 4 bits, insert the digit in the LS nibble, digit_cnt+1.
  - Digits beyond PIN_DIGITS are ignored (count saturates).
  - Clear: buffer=0, digit_cnt=0.
  - Enter with digit_cnt==PIN_DIGITS -> CHECK. Enter with fewer digits is ignored (no try consumed).
  - card_in is ignored in all non-IDLE states.
- CHECK (exactly one cycle):
  - Match -> GRANTED; auth_ok=1 on the following edge. Latency: enter accepted at edge N -> auth_ok high after edge N+2.
  - Mismatch with tries_left>1 -> tries_left-1, bad_pin pulse, clear buffer and digit_cnt, return to COLLECT.
  - Mismatch with tries_left==1 -> tries_left=0, card_retain pulse, card_id=0, go to IDLE.
- GRANTED:
  - auth_ok held at 1; keys ignored.
  - session_end -> auth_ok=0, card_id=0, buffer cleared, go to IDLE on the next edge.
  - session_end in any other state is ignored.
- Simultaneous key_valid and session_end in GRANTED: session_end wins.
- Reset mid-operation: immediate return to reset values regardless of state; no pulse is emitted.
- The PIN buffer never leaves the block; only the compare result is exposed.

Optional Feature:
- ATM_TIMEOUT_EN defined:
  - An inactivity counter runs in COLLECT, cleared on entry and on every key_valid.
  - When the counter reaches TIMEOUT_CYC-1 with no key -> timeout pulse, card_id=0, go to IDLE.
  - A key arriving in the same cycle wins: it clears the counter and no timeout fires.
- Not defined: no counter and no timeout logic; the timeout output is tied to 0; COLLECT waits indefinitely.

Decomposition:
- Shared package atm_pkg holds:
  - the state enum;
  - key-code constants KEY_CLEAR=4'hA and KEY_ENTER=4'hB;
  - the card-number width constant (8);
  - a function returning the counter width.
- One natural sub-module, atm_pin_shift_reg: the BCD digit shifter/counter with clear, saturation and compare output.
- The FSM, try counter and timeout logic stay in the top block.

Test Plan:
- Card 8'h5A, keys 1,2,3,4,enter, ref_pin 16'h1234 -> auth_ok=1 two edges after enter, card_id=8'h5A, tries_left=3; session_end -> auth_ok=0, card_id=0.
- Keys 9,9,9,9,enter (wrong) once, then 1,2,3,4,enter -> one bad_pin pulse, tries_left=2, then auth_ok=1.
- Three wrong 4-digit entries -> bad_pin pulses at tries 3->2 and 2->1, card_retain pulse on the third, state IDLE, card_id=0.
- Keys 1,2,clear,1,2,3,4,5,enter -> digit_cnt shows 2, 0, then saturates at 4 (5 ignored); compares 1234 -> auth_ok=1. Enter after only 3 digits -> no state change.
- ATM_TIMEOUT_EN, TIMEOUT_CYC=20: card in, no keys -> timeout pulse exactly 20 cycles after COLLECT entry, IDLE. A key at cycle 19 -> no timeout, counter restarts.
- rst asserted in GRANTED, asynchronously mid-cycle -> auth_ok and card_id drop immediately; card_in afterwards starts a fresh session with tries_left=3.
